// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment driver with a sequential double-dabble
// binary-to-BCD converter, leading-zero blanking, decimal points and overflow dashes.
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int BIN_W          = 14,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [BIN_W-1:0]  load_value,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              blank_lz,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_sel
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          CNT_W     = $clog2(SCAN_DIV);
    localparam int          STEP_W    = $clog2(BIN_W + 1);
    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);
    localparam logic [6:0]  SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic        DP_INV    = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            nib = b[4*k +: 4];
            if (nib >= 4'd5) begin
                r[4*k +: 4] = nib + 4'd3;
            end else begin
                r[4*k +: 4] = nib;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic               load_ready_r;
    logic [BIN_W-1:0]   bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [STEP_W-1:0]  step_r;
    logic [DIGITS-1:0]  cap_dp_r;
    logic               cap_blank_r;
    logic               cap_ovf_r;
    logic [BCD_W-1:0]   disp_bcd_r;
    logic [DIGITS-1:0]  disp_dp_r;
    logic               disp_blank_r;
    logic               disp_ovf_r;

    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;

    logic [BCD_W-1:0]   bcd_next_s;
    logic [DIGITS-1:0]  lead_zero_s;
    logic [DIGITS-1:0]  sel_s;
    logic [3:0]         nib_s;
    logic               blank_s;
    logic               dp_s;
    logic [6:0]         seg_s;

    logic [6:0]         seg_r;
    logic               dp_r;
    logic [DIGITS-1:0]  dig_sel_r;

    // One double-dabble step: adjust nibbles, then shift the next binary bit in.
    always_comb begin
        logic [BCD_W-1:0] adj;
        adj        = add3_nibbles(bcd_r);
        bcd_next_s = {adj[BCD_W-2:0], bin_r[BIN_W-1]};
    end

    // Load/convert/commit sequencer; display registers only change in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            load_ready_r <= 1'b1;
            bin_r        <= '0;
            bcd_r        <= '0;
            step_r       <= '0;
            cap_dp_r     <= '0;
            cap_blank_r  <= 1'b0;
            cap_ovf_r    <= 1'b0;
            disp_bcd_r   <= '0;
            disp_dp_r    <= '0;
            disp_blank_r <= 1'b0;
            disp_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_valid) begin
                        bin_r        <= load_value;
                        bcd_r        <= '0;
                        step_r       <= '0;
                        cap_dp_r     <= dp_mask;
                        cap_blank_r  <= blank_lz;
                        cap_ovf_r    <= (64'(load_value) >= OVF_LIMIT);
                        load_ready_r <= 1'b0;
                        state_r      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_r  <= bcd_next_s;
                    bin_r  <= bin_r << 1;
                    step_r <= step_r + STEP_W'(1);
                    if (step_r == STEP_W'(BIN_W - 1)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    disp_bcd_r   <= bcd_r;
                    disp_dp_r    <= cap_dp_r;
                    disp_blank_r <= cap_blank_r;
                    disp_ovf_r   <= cap_ovf_r;
                    load_ready_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    load_ready_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan timer: dwell SCAN_DIV cycles per digit, index runs from the top digit down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= IDX_W'(DIGITS - 1);
        end else if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
            cnt_r <= '0;
            if (idx_r == IDX_W'(0)) begin
                idx_r <= IDX_W'(DIGITS - 1);
            end else begin
                idx_r <= idx_r - IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Leading-zero map: bit i set when digits DIGITS-1..i are all zero.
    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        lead_zero_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero       = all_zero & (disp_bcd_r[4*i +: 4] == 4'd0);
            lead_zero_s[i] = all_zero;
        end
    end

    // Select the scanned digit's nibble, blanking and decimal point.
    always_comb begin
        sel_s   = '0;
        nib_s   = 4'd0;
        blank_s = 1'b0;
        dp_s    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                sel_s[i] = 1'b1;
                nib_s    = disp_bcd_r[4*i +: 4];
                blank_s  = disp_blank_r && (i > 0) && lead_zero_s[i];
                dp_s     = disp_dp_r[i];
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    // Overflow dashes take priority over blanking.
    always_comb begin
        seg_s = 7'h00;
        if (disp_ovf_r) begin
            seg_s = 7'h40;
        end else if (blank_s) begin
            seg_s = 7'h00;
        end else begin
            seg_s = seg_encode(nib_s);
        end
    end

    // Pin-facing output registers with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r     <= SEG_INV;
            dp_r      <= DP_INV;
            dig_sel_r <= DIG_INV;
        end else begin
            seg_r     <= seg_s ^ SEG_INV;
            dp_r      <= dp_s ^ DP_INV;
            dig_sel_r <= sel_s ^ DIG_INV;
        end
    end

    assign load_ready = load_ready_r;
    assign overflow   = disp_ovf_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign dig_sel    = dig_sel_r;

endmodule
